// File: rtl/pwm_pkg.sv
// Shared types and helpers for the multiphase PWM stage.
// Soft-start behaviour is selected at build time by PWM_SOFTSTART_EN (see pwm_multiphase_ss).
package pwm_pkg;

  // Soft-start sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    RUN  = 2'd2
  } ss_state_t;

  // Default width of the per-phase deadtime down-counter.
  localparam int DT_CNT_W = 4;

  // Carrier offset of phase k: k * 2^cnt_w / n_ph counts.
  function automatic int unsigned phase_offset(input int unsigned k,
                                               input int unsigned n_ph,
                                               input int unsigned cnt_w);
    return (k * (32'd1 << cnt_w)) / n_ph;
  endfunction

endpackage

// File: rtl/pwm_deadtime.sv
// Complementary gate driver for one phase with independent rising-edge deadtimes.
// A raw edge drops the active gate; the opposite gate rises dt cycles later
// (dt1 before hi, dt2 before lo). A new raw edge during the dead interval
// restarts it toward the new side, so hi and lo are never high together.
module pwm_deadtime
  import pwm_pkg::*;
#(
  parameter int DT_W = DT_CNT_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            raw,
  input  logic [DT_W-1:0] dt1,
  input  logic [DT_W-1:0] dt2,
  output logic            hi,
  output logic            lo
);

  logic            raw_q;   // side the gates are currently heading to
  logic            armed;   // cleared while disabled so re-enable starts a fresh dead interval
  logic [DT_W-1:0] dt_cnt;  // remaining dead cycles, 0 = settled
  logic [DT_W-1:0] dt_sel;

  assign dt_sel = raw ? dt1 : dt2;

  // Edge detection, dead-interval countdown and gate update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi     <= 1'b0;
      lo     <= 1'b0;
      raw_q  <= 1'b0;
      armed  <= 1'b0;
      dt_cnt <= '0;
    end else if (!en) begin
      hi     <= 1'b0;
      lo     <= 1'b0;
      raw_q  <= 1'b0;
      armed  <= 1'b0;
      dt_cnt <= '0;
    end else if (!armed || (raw != raw_q)) begin
      raw_q <= raw;
      armed <= 1'b1;
      if (dt_sel == '0) begin
        hi     <= raw;
        lo     <= ~raw;
        dt_cnt <= '0;
      end else begin
        hi     <= 1'b0;
        lo     <= 1'b0;
        dt_cnt <= dt_sel;
      end
    end else if (dt_cnt == DT_W'(1)) begin
      hi     <= raw_q;
      lo     <= ~raw_q;
      dt_cnt <= '0;
    end else if (dt_cnt != '0) begin
      dt_cnt <= dt_cnt - DT_W'(1);
    end
  end

endmodule

// File: rtl/pwm_multiphase_ss.sv
// N-phase complementary PWM generator with per-edge deadtime and soft start.
// Carrier, duty/deadtime shadows (loaded at carrier wrap), soft-start FSM and
// per-phase compare; each phase feeds a pwm_deadtime instance.
// Build option: PWM_SOFTSTART_EN defined -> IDLE ramps through RAMP to RUN;
// undefined -> IDLE goes straight to RUN and takes the target at the next wrap.
module pwm_multiphase_ss
  import pwm_pkg::*;
#(
  parameter int N_PH   = 2,
  parameter int CNT_W  = 8,
  parameter int DT_W   = 4,
  parameter int SS_DIV = 4,
  parameter int SS_INC = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_enable,
  input  logic [CNT_W-1:0] i_duty,
  input  logic [DT_W-1:0]  i_dt1,
  input  logic [DT_W-1:0]  i_dt2,
  output logic [N_PH-1:0]  o_hi,
  output logic [N_PH-1:0]  o_lo,
  output logic             o_sync,
  output logic             o_ss_done
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam int               SS_CW   = (SS_DIV > 1) ? $clog2(SS_DIV) : 1;
  localparam logic [SS_CW-1:0] SS_LAST = SS_CW'(SS_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] tgt;
  logic [CNT_W-1:0] duty_eff;
  logic [CNT_W-1:0] duty_nxt;
  logic [DT_W-1:0]  dt1_s;
  logic [DT_W-1:0]  dt2_s;
  logic [SS_CW-1:0] ss_cnt;
  logic [SS_CW-1:0] ss_nxt;
  logic [CNT_W:0]   ramp_sum;
  ss_state_t        state;
  ss_state_t        state_nxt;
  logic             wrap;
  logic             gate_en;

  assign wrap      = (cnt == CNT_MAX);
  assign o_sync    = wrap;
  assign o_ss_done = (state == RUN) && (duty_eff == tgt);
  // Gates drop on the same edge that samples i_enable low, not a cycle later.
  assign gate_en   = i_enable && (state != IDLE);
  assign ramp_sum  = {1'b0, duty_eff} + (CNT_W+1)'(SS_INC);

  // Free-running carrier; keeps counting while disabled so o_sync never stops.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt + CNT_W'(1);
  end

  // Shadow registers: take new target and deadtimes only at the wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgt   <= '0;
      dt1_s <= '0;
      dt2_s <= '0;
    end else if (wrap) begin
      tgt   <= i_duty;
      dt1_s <= i_dt1;
      dt2_s <= i_dt2;
    end
  end

  // Soft-start next-state and effective-duty logic; updates land at the wrap
  // so the new duty applies from cnt == 0 together with the shadows.
  always_comb begin
    // NOTE: defaults first so every path assigns every output -- no latches.
    state_nxt = state;
    duty_nxt  = duty_eff;
    ss_nxt    = ss_cnt;
    if (!i_enable) begin
      state_nxt = IDLE;
      duty_nxt  = '0;
      ss_nxt    = '0;
    end else begin
      case (state)
        IDLE: begin
          duty_nxt = '0;
          ss_nxt   = '0;
`ifdef PWM_SOFTSTART_EN
          state_nxt = RAMP;
`else
          state_nxt = RUN;
`endif
        end
        RAMP: begin
          if (wrap) begin
            if (i_duty < duty_eff) begin
              duty_nxt  = i_duty;
              state_nxt = RUN;
              ss_nxt    = '0;
            end else if (ss_cnt == SS_LAST) begin
              ss_nxt = '0;
              if (ramp_sum >= {1'b0, i_duty}) begin
                duty_nxt  = i_duty;
                state_nxt = RUN;
              end else begin
                duty_nxt = ramp_sum[CNT_W-1:0];
              end
            end else begin
              ss_nxt = ss_cnt + SS_CW'(1);
            end
          end
        end
        RUN: begin
          if (wrap) duty_nxt = i_duty;
        end
        default: begin
          state_nxt = IDLE;
          duty_nxt  = '0;
          ss_nxt    = '0;
        end
      endcase
    end
  end

  // Soft-start state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      duty_eff <= '0;
      ss_cnt   <= '0;
    end else begin
      state    <= state_nxt;
      duty_eff <= duty_nxt;
      ss_cnt   <= ss_nxt;
    end
  end

  // Per-phase shifted compare and deadtime driver.
  for (genvar k = 0; k < N_PH; k++) begin : g_ph
    localparam logic [CNT_W-1:0] OFF = CNT_W'(phase_offset(k, N_PH, CNT_W));

    logic [CNT_W-1:0] c_k;
    logic             raw_k;

    assign c_k = cnt + OFF;

    // Registered compare: high for duty_eff counts of each carrier period.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) raw_k <= 1'b0;
      else        raw_k <= (c_k < duty_eff);
    end

    pwm_deadtime #(.DT_W(DT_W)) u_dt (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (gate_en),
      .raw   (raw_k),
      .dt1   (dt1_s),
      .dt2   (dt2_s),
      .hi    (o_hi[k]),
      .lo    (o_lo[k])
    );
  end

endmodule

// File: tb/tb_pwm_multiphase_ss.sv
// Bench for pwm_multiphase_ss (N_PH=2, CNT_W=8, DT_W=4, SS_DIV=4, SS_INC=1).
// Expected values are queued when stimulus is applied and compared once the
// corresponding output window has been observed. PWM_SOFTSTART_EN selects
// the soft-start scenarios instead of the direct-run ones.
module tb_pwm_multiphase_ss;

  localparam int PERIOD = 256;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_enable = 1'b0;
  logic [7:0] i_duty = '0;
  logic [3:0] i_dt1 = '0;
  logic [3:0] i_dt2 = '0;
  logic [1:0] o_hi;
  logic [1:0] o_lo;
  logic       o_sync;
  logic       o_ss_done;

  pwm_multiphase_ss #(
    .N_PH(2), .CNT_W(8), .DT_W(4), .SS_DIV(4), .SS_INC(1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_enable  (i_enable),
    .i_duty    (i_duty),
    .i_dt1     (i_dt1),
    .i_dt2     (i_dt2),
    .o_hi      (o_hi),
    .o_lo      (o_lo),
    .o_sync    (o_sync),
    .o_ss_done (o_ss_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    val;
  } exp_t;

  typedef struct {
    int   hi0;
    int   lo0;
    int   hi1;
    int   ovl;
    int   rise0;
    int   rise1;
    logic done;
  } meas_t;

  exp_t sb[$];
  int   n_run = 0;
  int   n_fail = 0;
  int   cyc = 0;

  logic [1:0] cur_hi, cur_lo, prev_hi, prev_lo;
  logic       cur_sync, prev_sync, cur_done;

  task automatic push(input string n, input int v);
    exp_t e;
    e.name = n;
    e.val  = v;
    sb.push_back(e);
  endtask

  // One sample per falling edge, away from the active edge.
  task automatic step();
    @(negedge clk);
    cyc++;
    prev_hi   = cur_hi;
    prev_lo   = cur_lo;
    prev_sync = cur_sync;
    cur_hi    = o_hi;
    cur_lo    = o_lo;
    cur_sync  = o_sync;
    cur_done  = o_ss_done;
  endtask

  function automatic logic pick(input int sel, input logic [1:0] hi, input logic [1:0] lo,
                                input logic sy);
    case (sel)
      0:       return hi[0];
      1:       return lo[0];
      2:       return hi[1];
      default: return sy;
    endcase
  endfunction

  // Wait (bounded) for signal sel to change to lvl.
  task automatic wait_edge(input int sel, input logic lvl, input string what, output bit found);
    found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      step();
      if (pick(sel, prev_hi, prev_lo, prev_sync) !== lvl &&
          pick(sel, cur_hi, cur_lo, cur_sync) === lvl) found = 1'b1;
    end
    if (!found) begin
      n_run++;
      n_fail++;
      $display("FAIL timeout %s: got no transition in 600 cycles, required one", what);
    end
  endtask

  // Observe one full carrier period (cnt 0..255), optionally aligned to the next sync.
  task automatic measure(input bit need_sync, output meas_t m);
    bit ok;
    m.hi0 = 0; m.lo0 = 0; m.hi1 = 0; m.ovl = 0; m.rise0 = -1; m.rise1 = -1; m.done = 1'b0;
    if (need_sync) wait_edge(3, 1'b1, "sync", ok);
    for (int i = 0; i < PERIOD; i++) begin
      step();
      m.hi0 += int'(cur_hi[0]);
      m.lo0 += int'(cur_lo[0]);
      m.hi1 += int'(cur_hi[1]);
      if ((cur_hi & cur_lo) != 2'b00) m.ovl++;
      if (m.rise0 < 0 && prev_hi[0] === 1'b0 && cur_hi[0] === 1'b1) m.rise0 = i;
      if (m.rise0 >= 0 && m.rise1 < 0 && prev_hi[1] === 1'b0 && cur_hi[1] === 1'b1) m.rise1 = i;
    end
    m.done = cur_done;
  endtask

  task automatic test_reset();
    exp_t e;
    bit   ok;
    int   base;
    rst_n = 1'b0;
    i_enable = 1'b0;
    push("reset gates", 0);
    push("reset sync/done", 0);
    push("first sync after release", 255);
    push("sync spacing", PERIOD);
    repeat (3) step();
    e = sb.pop_front(); n_run++;
    if ({cur_hi, cur_lo} !== 4'b0000) begin
      n_fail++; $display("FAIL %s: got %b, expected 0", e.name, {cur_hi, cur_lo});
    end
    e = sb.pop_front(); n_run++;
    if ({cur_sync, cur_done} !== 2'b00) begin
      n_fail++; $display("FAIL %s: got %b, expected 0", e.name, {cur_sync, cur_done});
    end
    rst_n = 1'b1;
    base = cyc;
    wait_edge(3, 1'b1, "first sync", ok);
    e = sb.pop_front(); n_run++;
    if (cyc - base !== e.val) begin
      n_fail++; $display("FAIL %s: got %0d, expected %0d", e.name, cyc - base, e.val);
    end
    base = cyc;
    wait_edge(3, 1'b1, "second sync", ok);
    e = sb.pop_front(); n_run++;
    if (cyc - base !== e.val) begin
      n_fail++; $display("FAIL %s: got %0d, expected %0d", e.name, cyc - base, e.val);
    end
  endtask

  task automatic test_duty_half();
    exp_t  e;
    meas_t m;
    bit    ok;
    i_duty = 8'd128; i_dt1 = 4'd0; i_dt2 = 4'd0; i_enable = 1'b1;
    push("half hi0 count", 128);
    push("half lo0 count", 128);
    push("half overlap", 0);
    push("half hi1 count", 128);
    push("phase shift", 128);
    push("half ss_done", 1);
    wait_edge(3, 1'b1, "sync", ok);
    measure(1'b1, m);
    e = sb.pop_front(); n_run++;
    if (m.hi0 !== e.val) begin n_fail++; $display("FAIL %s: got %0d, expected %0d", e.name, m.hi0, e.val); end
    e = sb.pop_front(); n_run++;
    if (m.lo0 !== e.val) begin n_fail++; $display("FAIL %s: got %0d, expected %0d", e.name, m.lo0, e.val); end
    e = sb.pop_front(); n_run++;
    if (m.ovl !== e.val) begin n_fail++; $display("FAIL %s: got %0d, expected %0d", e.name, m.ovl, e.val); end
    e = sb.pop_front(); n_run++;
    if (m.hi1 !== e.val) begin n_fail++; $display("FAIL %s: got %0d, expected %0d", e.name, m.hi1, e.val); end
    e = sb.pop_front(); n_run++;
    if (m.rise1 - m.rise0 !== e.val || m.rise0 < 0) begin
      n_fail++; $display("FAIL %s: got %0d (rise0 %0d), expected %0d", e.name, m.rise1 - m.rise0, m.rise0, e.val);
    end
    e = sb.pop_front(); n_run++;
    if (int'(m.done) !== e.val) begin n_fail++; $display("FAIL %s: got %0d, expected %0d", e.name, m.done, e.val); end
  endtask

  task automatic test_deadtime();
    exp_t  e;
    meas_t m;
    bit    ok;
    int    a;
    i_duty = 8'd64; i_dt1 = 4'd3; i_dt2 = 4'd5;
    push("dt hi0 count", 64 - 3);
    push("dt lo0 count", 256 - 64 - 5);
    push("dt overlap", 0);
    push("dt1 gap lo-fall to hi-rise", 3);
    push("dt2 gap hi-fall to lo-rise", 5);
    wait_edge(3, 1'b1, "sync", ok);
    measure(1'b1, m);
    e = sb.pop_front(); n_run++;
    if (m.hi0 !== e.val) begin n_fail++; $display("FAIL %s: got %0d, expected %0d", e.name, m.hi0, e.val); end
    e = sb.pop_front(); n_run++;
    if (m.lo0 !== e.val) begin n_fail++; $display("FAIL %s: got %0d, expected %0d", e.name, m.lo0, e.val); end
    e = sb.pop_front(); n_run++;
    if (m.ovl !== e.val) begin n_fail++; $display("FAIL %s: got %0d, expected %0d", e.name, m.ovl, e.val); end
    wait_edge(1, 1'b0, "lo0 fall", ok);
    a = cyc;
    wait_edge(0, 1'b1, "hi0 rise", ok);
    e = sb.pop_front(); n_run++;
    if (cyc - a !== e.val) begin n_fail++; $display("FAIL %s: got %0d, expected %0d", e.name, cyc - a, e.val); end
    wait_edge(0, 1'b0, "hi0 fall", ok);
    a = cyc;
    wait_edge(1, 1'b1, "lo0 rise", ok);
    e = sb.pop_front(); n_run++;
    if (cyc - a !== e.val) begin n_fail++; $display("FAIL %s: got %0d, expected %0d", e.name, cyc - a, e.val); end
  endtask

  task automatic test_boundaries();
    exp_t  e;
    meas_t m;
    bit    ok;
    logic [7:0] duties [2] = '{8'd0, 8'd255};
    for (int j = 0; j < 2; j++) begin
      i_duty = duties[j]; i_dt1 = 4'd0; i_dt2 = 4'd0;
      push($sformatf("duty %0d hi0 count", duties[j]), int'(duties[j]));
      push($sformatf("duty %0d lo0 count", duties[j]), PERIOD - int'(duties[j]));
      wait_edge(3, 1'b1, "sync", ok);
      measure(1'b1, m);
      e = sb.pop_front(); n_run++;
      if (m.hi0 !== e.val) begin n_fail++; $display("FAIL %s: got %0d, expected %0d", e.name, m.hi0, e.val); end
      e = sb.pop_front(); n_run++;
      if (m.lo0 !== e.val) begin n_fail++; $display("FAIL %s: got %0d, expected %0d", e.name, m.lo0, e.val); end
    end
  endtask

`ifdef PWM_SOFTSTART_EN
  task automatic test_softstart();
    exp_t  e;
    meas_t m;
    int    last = 0;
    int    run = 0;
    i_duty = 8'd10; i_dt1 = 4'd0; i_dt2 = 4'd0; i_enable = 1'b1;
    for (int v = 1; v <= 10; v++) push($sformatf("ramp step %0d", v), v);
    measure(1'b1, m);
    for (int w = 0; w < 80; w++) begin
      if (m.hi0 != last) begin
        if (last > 0) begin
          n_run++;
          if (run !== 4) begin n_fail++; $display("FAIL ramp hold at %0d: got %0d periods, expected 4", last, run); end
        end
        if (sb.size() > 0) begin
          e = sb.pop_front(); n_run++;
          if (m.hi0 !== e.val) begin n_fail++; $display("FAIL %s: got %0d, expected %0d", e.name, m.hi0, e.val); end
          n_run++;
          if (m.done !== (e.val == 10)) begin
            n_fail++; $display("FAIL ss_done at %s: got %0d, expected %0d", e.name, m.done, e.val == 10);
          end
        end
        last = m.hi0;
        run  = 0;
      end
      run++;
      if (last >= 10) break;
      measure(1'b0, m);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front(); n_run++; n_fail++;
      $display("FAIL %s: got no such period, expected %0d", e.name, e.val);
    end
  endtask

  task automatic test_ramp_lower();
    exp_t  e;
    meas_t m;
    i_enable = 1'b0;
    repeat (3) step();
    i_duty = 8'd10; i_enable = 1'b1;
    measure(1'b1, m);
    for (int w = 0; w < 60 && m.hi0 != 6; w++) measure(1'b0, m);
    i_duty = 8'd3;
    push("lowered duty", 3);
    push("ss_done after lower", 1);
    measure(1'b0, m);
    e = sb.pop_front(); n_run++;
    if (m.hi0 !== e.val) begin n_fail++; $display("FAIL %s: got %0d, expected %0d", e.name, m.hi0, e.val); end
    e = sb.pop_front(); n_run++;
    if (int'(m.done) !== e.val) begin n_fail++; $display("FAIL %s: got %0d, expected %0d", e.name, m.done, e.val); end
  endtask
`endif

  task automatic test_enable_drop();
    exp_t  e;
    meas_t m;
    bit    ok;
    bit    seen = 1'b0;
    i_duty = 8'd128; i_dt1 = 4'd0; i_dt2 = 4'd0;
    push("gates after disable", 0);
    push("ss_done after disable", 0);
    push("sync while disabled", 1);
`ifdef PWM_SOFTSTART_EN
    push("re-enable duty", 0);
`else
    push("re-enable duty", 128);
`endif
    wait_edge(3, 1'b1, "sync", ok);
    wait_edge(3, 1'b1, "sync", ok);
    for (int i = 0; i < 600 && !seen; i++) begin
      step();
      seen = (cur_hi[0] === 1'b1);
    end
    i_enable = 1'b0;
    step();
    e = sb.pop_front(); n_run++;
    if ({cur_hi, cur_lo} !== 4'b0000 || !seen) begin
      n_fail++; $display("FAIL %s: got %b (hi seen %0d), expected 0", e.name, {cur_hi, cur_lo}, seen);
    end
    e = sb.pop_front(); n_run++;
    if (int'(cur_done) !== e.val) begin n_fail++; $display("FAIL %s: got %0d, expected %0d", e.name, cur_done, e.val); end
    wait_edge(3, 1'b1, "sync disabled", ok);
    e = sb.pop_front(); n_run++;
    if (int'(ok) !== e.val) begin n_fail++; $display("FAIL %s: got %0d, expected %0d", e.name, ok, e.val); end
    i_enable = 1'b1;
    wait_edge(3, 1'b1, "sync", ok);
    measure(1'b1, m);
    e = sb.pop_front(); n_run++;
    if (m.hi0 !== e.val) begin n_fail++; $display("FAIL %s: got %0d, expected %0d", e.name, m.hi0, e.val); end
  endtask

  task automatic test_async_reset();
    exp_t e;
    bit   ok;
    int   base;
    i_dt1 = 4'd4; i_dt2 = 4'd4;
    push("outputs during async reset", 0);
    push("first sync after mid-run reset", 255);
    wait_edge(3, 1'b1, "sync", ok);
    wait_edge(3, 1'b1, "sync", ok);
    wait_edge(1, 1'b0, "lo0 fall", ok);
    #1 rst_n = 1'b0;
    #1;
    e = sb.pop_front(); n_run++;
    if ({o_hi, o_lo, o_sync, o_ss_done} !== 6'b000000) begin
      n_fail++; $display("FAIL %s: got %b, expected 0", e.name, {o_hi, o_lo, o_sync, o_ss_done});
    end
    step();
    rst_n = 1'b1;
    base = cyc;
    wait_edge(3, 1'b1, "sync after reset", ok);
    e = sb.pop_front(); n_run++;
    if (cyc - base !== e.val) begin n_fail++; $display("FAIL %s: got %0d, expected %0d", e.name, cyc - base, e.val); end
  endtask

  initial begin
    test_reset();
`ifdef PWM_SOFTSTART_EN
    test_softstart();
    test_ramp_lower();
`else
    test_duty_half();
    test_deadtime();
    test_boundaries();
`endif
    test_enable_drop();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
